// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: access sizes, FSM states and a
// helper that converts an access size into a byte count.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    HWORD = 2'b01,
    WORD  = 2'b10
  } mem_op_sz_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } arb_state_e;

  // Byte count of an access; 0 marks an encoding that is not a legal size.
  function automatic logic [2:0] mem_op_bytes(input mem_op_sz_e sz);
    logic [2:0] n;
    case (sz)
      BYTE:    n = 3'd1;
      HWORD:   n = 3'd2;
      WORD:    n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way arbiter. With both requests high the port that did not win the
// last accepted grant wins (or port 0 when fixed priority is selected).
// A single request always wins. History only moves on an accepted grant.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  input  logic       i_fixed,
  output logic [1:0] o_gnt
);

  logic last_q;
  logic last_d;

  // Grant selection from the current requests and the last-grant history.
  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = (i_fixed || last_q) ? 2'b01 : 2'b10;
    end
  end

  // Remember which port won, but only when the grant was actually taken.
  always_comb begin
    last_d = last_q;
    if (i_accept && (o_gnt != 2'b00)) begin
      last_d = o_gnt[1];
    end
  end

  // Last-grant register; starts at port 1 so port 0 wins the first tie.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester controller for data_mem. Accepts one request at a time,
// checks alignment/range/size up front, strobes memory for exactly one
// cycle and returns a one-cycle registered response to the requester.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MemoryBytesSize = 'h8,
  parameter bit FixedPriority   = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic        i_req0_we,
  input  logic [31:0] i_req0_addr,
  input  logic [31:0] i_req0_wdata,
  input  mem_op_sz_e  i_req0_size,
  output logic        o_rsp0_valid,
  output logic [31:0] o_rsp0_rdata,
  output logic        o_rsp0_err,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic        i_req1_we,
  input  logic [31:0] i_req1_addr,
  input  logic [31:0] i_req1_wdata,
  input  mem_op_sz_e  i_req1_size,
  output logic        o_rsp1_valid,
  output logic [31:0] o_rsp1_rdata,
  output logic        o_rsp1_err,
  output logic        o_mem_we,
  output logic        o_mem_re,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output mem_op_sz_e  o_mem_size,
  input  logic [31:0] i_mem_rdata
);

  // First byte address past the end of data_mem, in 33 bits so that
  // address + length never wraps.
  localparam logic [32:0] MemLimit = 33'(MemoryBytesSize) << 2;

  arb_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  mem_op_sz_e  size_q, size_d;
  logic        port_q, port_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [1:0]  arb_req;
  logic [1:0]  gnt;
  logic        accept;

  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  mem_op_sz_e  sel_size;
  logic [2:0]  sel_bytes;
  logic [32:0] sel_end;
  logic        sel_err;

  // Requests are only offered to the arbiter while the controller is idle.
  assign arb_req = {i_req1_valid, i_req0_valid} & {2{state_q == IDLE}};
  assign accept  = |gnt;

  rr_arb2 u_rr_arb2 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req   (arb_req),
    .i_accept(accept),
    .i_fixed (FixedPriority),
    .o_gnt   (gnt)
  );

  // Select the granted request and work out up front whether it is legal.
  always_comb begin
    sel_we    = gnt[1] ? i_req1_we    : i_req0_we;
    sel_addr  = gnt[1] ? i_req1_addr  : i_req0_addr;
    sel_wdata = gnt[1] ? i_req1_wdata : i_req0_wdata;
    sel_size  = gnt[1] ? i_req1_size  : i_req0_size;
    sel_bytes = mem_op_bytes(sel_size);
    sel_end   = {1'b0, sel_addr} + {30'b0, sel_bytes};
    sel_err   = (sel_bytes == 3'd0)
              || ((sel_size == HWORD) && sel_addr[0])
              || ((sel_size == WORD) && (sel_addr[1:0] != 2'b00))
              || (sel_end > MemLimit);
  end

  // Sequencer: accept in IDLE, strobe memory in ACCESS, respond in RESP.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    port_d       = port_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    o_rsp0_valid = 1'b0;
    o_rsp0_rdata = '0;
    o_rsp0_err   = 1'b0;
    o_rsp1_valid = 1'b0;
    o_rsp1_rdata = '0;
    o_rsp1_err   = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_re     = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    o_mem_size   = BYTE;
    case (state_q)
      IDLE: begin
        o_req0_ready = gnt[0];
        o_req1_ready = gnt[1];
        if (accept) begin
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          size_d  = sel_size;
          port_d  = gnt[1];
          err_d   = sel_err;
          rdata_d = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!err_q) begin
          o_mem_we    = we_q;
          o_mem_re    = !we_q;
          o_mem_addr  = addr_q;
          o_mem_wdata = wdata_q;
          o_mem_size  = size_q;
        end
        rdata_d = (!err_q && !we_q) ? i_mem_rdata : '0;
        state_d = RESP;
      end
      RESP: begin
        o_rsp0_valid = !port_q;
        o_rsp0_rdata = port_q ? '0 : rdata_q;
        o_rsp0_err   = !port_q && err_q;
        o_rsp1_valid = port_q;
        o_rsp1_rdata = port_q ? rdata_q : '0;
        o_rsp1_err   = port_q && err_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and transaction latch; reset drops any in-flight access.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= BYTE;
      port_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      port_q  <= port_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a byte-array data_mem stand-in, a transaction-level
// reference model (one accept per three cycles, strobe one cycle after accept,
// response two cycles after) and a per-cycle compare of every output.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int MemBytes  = 'h8 * 4;
  localparam int MaxCycles = 8000;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    mem_op_sz_e  size;
    int          gap;
  } req_t;

  typedef struct {
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    mem_op_sz_e  size;
  } memEv_t;

  typedef struct {
    logic        valid;
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } rspEv_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid [2];
  logic        reqReady [2];
  logic        reqWe    [2];
  logic [31:0] reqAddr  [2];
  logic [31:0] reqWdata [2];
  mem_op_sz_e  reqSize  [2];
  logic        rspValid [2];
  logic [31:0] rspRdata [2];
  logic        rspErr   [2];
  logic        memWe, memRe;
  logic [31:0] memAddr, memWdata, memRdata;
  mem_op_sz_e  memSize;

  logic        fpValid    [2];
  logic        fpReady    [2];
  logic        fpRspValid [2];
  logic [31:0] fpRspRdata [2];
  logic        fpRspErr   [2];
  logic        fpMemWe, fpMemRe;
  logic [31:0] fpMemAddr, fpMemWdata;
  mem_op_sz_e  fpMemSize;
  logic        fpWe    = 1'b0;
  logic [31:0] fpAddr0 = 32'h0;
  logic [31:0] fpAddr1 = 32'h4;
  logic [31:0] fpWdata = 32'h0;
  mem_op_sz_e  fpSize  = WORD;
  logic [31:0] fpRdata = 32'h0;

  logic [7:0]  dmem [MemBytes];
  logic [7:0]  mdl  [MemBytes];
  memEv_t      expMem [MaxCycles];
  rspEv_t      expRsp [MaxCycles];
  logic        expReady [2];
  req_t        q0 [$];
  req_t        q1 [$];
  int          holdCnt [2];
  int          cyc;
  int          nextFree;
  int          lastGnt;
  int          checkCount;
  int          passCount;
  int          weCount;
  int          reCount;
  int          fpRspCount;
  int          fpErrCount;
  logic [31:0] lastRdata [2];
  logic        lastErr   [2];
  int          gntLog [$];
  int          fpLog  [$];

  always #5 clk = ~clk;

  dmem_arbiter #(.MemoryBytesSize('h8), .FixedPriority(1'b0)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(reqValid[0]), .o_req0_ready(reqReady[0]), .i_req0_we(reqWe[0]),
    .i_req0_addr(reqAddr[0]), .i_req0_wdata(reqWdata[0]), .i_req0_size(reqSize[0]),
    .o_rsp0_valid(rspValid[0]), .o_rsp0_rdata(rspRdata[0]), .o_rsp0_err(rspErr[0]),
    .i_req1_valid(reqValid[1]), .o_req1_ready(reqReady[1]), .i_req1_we(reqWe[1]),
    .i_req1_addr(reqAddr[1]), .i_req1_wdata(reqWdata[1]), .i_req1_size(reqSize[1]),
    .o_rsp1_valid(rspValid[1]), .o_rsp1_rdata(rspRdata[1]), .o_rsp1_err(rspErr[1]),
    .o_mem_we(memWe), .o_mem_re(memRe), .o_mem_addr(memAddr), .o_mem_wdata(memWdata),
    .o_mem_size(memSize), .i_mem_rdata(memRdata)
  );

  dmem_arbiter #(.MemoryBytesSize('h8), .FixedPriority(1'b1)) dutFp (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(fpValid[0]), .o_req0_ready(fpReady[0]), .i_req0_we(fpWe),
    .i_req0_addr(fpAddr0), .i_req0_wdata(fpWdata), .i_req0_size(fpSize),
    .o_rsp0_valid(fpRspValid[0]), .o_rsp0_rdata(fpRspRdata[0]), .o_rsp0_err(fpRspErr[0]),
    .i_req1_valid(fpValid[1]), .o_req1_ready(fpReady[1]), .i_req1_we(fpWe),
    .i_req1_addr(fpAddr1), .i_req1_wdata(fpWdata), .i_req1_size(fpSize),
    .o_rsp1_valid(fpRspValid[1]), .o_rsp1_rdata(fpRspRdata[1]), .o_rsp1_err(fpRspErr[1]),
    .o_mem_we(fpMemWe), .o_mem_re(fpMemRe), .o_mem_addr(fpMemAddr), .o_mem_wdata(fpMemWdata),
    .o_mem_size(fpMemSize), .i_mem_rdata(fpRdata)
  );

  function automatic int sizeBytes(input mem_op_sz_e s);
    case (s)
      BYTE:    return 1;
      HWORD:   return 2;
      WORD:    return 4;
      default: return 0;
    endcase
  endfunction

  // An access is an error when its size is illegal, it is not naturally
  // aligned, or any of its bytes lies outside the memory.
  function automatic bit errRule(input logic [31:0] addr, input mem_op_sz_e s);
    longint a = longint'(addr);
    int     n = sizeBytes(s);
    return (n == 0) || ((a % n) != 0) || (a + n - 1 >= MemBytes);
  endfunction

  function automatic logic [31:0] readModel(input logic [31:0] addr, input mem_op_sz_e s);
    logic [31:0] r = '0;
    for (int k = 0; k < sizeBytes(s); k++) r[8*k +: 8] = mdl[int'(addr) + k];
    return r;
  endfunction

  // data_mem stand-in: combinational little-endian read, zero-extended.
  always_comb begin
    memRdata = '0;
    for (int k = 0; k < 4; k++) begin
      if ((k < sizeBytes(memSize)) && ({32'b0, memAddr} + 64'(k) < 64'(MemBytes)))
        memRdata[8*k +: 8] = dmem[int'(memAddr) + k];
    end
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  task automatic pushReq(input int port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input mem_op_sz_e size, input int gap);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata; r.size = size; r.gap = gap;
    if (port == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask

  // Drive this cycle's inputs and predict ready plus the scheduled strobe/response.
  task automatic applyStimulus(input bit doRst);
    req_t   h;
    bit     v [2];
    int     g;
    bit     e;
    rst = !doRst;
    if (doRst) begin
      for (int c = cyc; c < cyc + 3 && c < MaxCycles; c++) begin
        expMem[c].valid = 1'b0;
        expRsp[c].valid = 1'b0;
      end
      nextFree = cyc + 1;
      lastGnt  = 1;
      holdCnt[0] = 0;
      holdCnt[1] = 0;
    end else if (expMem[cyc].valid && expMem[cyc].we) begin
      for (int k = 0; k < sizeBytes(expMem[cyc].size); k++)
        mdl[int'(expMem[cyc].addr) + k] = expMem[cyc].wdata[8*k +: 8];
    end
    for (int p = 0; p < 2; p++) begin
      v[p] = 1'b0;
      reqWe[p]    = 1'($urandom_range(0, 1));
      reqAddr[p]  = $urandom;
      reqWdata[p] = $urandom;
      reqSize[p]  = mem_op_sz_e'(2'($urandom_range(0, 3)));
      if (!doRst && ((p == 0) ? q0.size() : q1.size()) > 0) begin
        h = (p == 0) ? q0[0] : q1[0];
        if (holdCnt[p] < h.gap) holdCnt[p]++;
        else begin
          v[p] = 1'b1;
          reqWe[p] = h.we; reqAddr[p] = h.addr; reqWdata[p] = h.wdata; reqSize[p] = h.size;
        end
      end
      reqValid[p] = v[p];
      expReady[p] = 1'b0;
    end
    if (cyc >= nextFree && (v[0] || v[1])) begin
      g = (v[0] && v[1]) ? 1 - lastGnt : (v[0] ? 0 : 1);
      h = (g == 0) ? q0.pop_front() : q1.pop_front();
      holdCnt[g]  = 0;
      expReady[g] = 1'b1;
      lastGnt     = g;
      nextFree    = cyc + 3;
      e = errRule(h.addr, h.size);
      expMem[cyc + 1] = '{valid: !e, we: h.we, addr: h.addr, wdata: h.wdata, size: h.size};
      expRsp[cyc + 2] = '{valid: 1'b1, port: 1'(g),
                          rdata: (!e && !h.we) ? readModel(h.addr, h.size) : 32'h0, err: e};
    end
  endtask

  // Compare every output with the prediction; also act as data_mem's write port.
  task automatic checkOutput();
    memEv_t m;
    rspEv_t r;
    bit     ev;
    m = expMem[cyc];
    r = expRsp[cyc];
    checkVal("req0_ready", 32'(reqReady[0]), 32'(expReady[0]));
    checkVal("req1_ready", 32'(reqReady[1]), 32'(expReady[1]));
    checkVal("mem_we", 32'(memWe), 32'(m.valid && m.we));
    checkVal("mem_re", 32'(memRe), 32'(m.valid && !m.we));
    checkVal("mem_addr", memAddr, m.valid ? m.addr : 32'h0);
    checkVal("mem_wdata", memWdata, m.valid ? m.wdata : 32'h0);
    checkVal("mem_size", 32'(memSize), m.valid ? 32'(m.size) : 32'h0);
    for (int p = 0; p < 2; p++) begin
      ev = r.valid && (int'(r.port) == p);
      checkVal($sformatf("rsp%0d_valid", p), 32'(rspValid[p]), 32'(ev));
      checkVal($sformatf("rsp%0d_rdata", p), rspRdata[p], ev ? r.rdata : 32'h0);
      checkVal($sformatf("rsp%0d_err", p), 32'(rspErr[p]), 32'(ev && r.err));
      if (reqReady[p]) gntLog.push_back(p);
      if (rspValid[p]) begin
        lastRdata[p] = rspRdata[p];
        lastErr[p]   = rspErr[p];
      end
      if (fpReady[p]) fpLog.push_back(p);
    end
    if (fpRspValid[0] || fpRspValid[1]) fpRspCount++;
    if (fpRspErr[0] || fpRspErr[1]) fpErrCount++;
    if (memRe) reCount++;
    if (memWe) begin
      weCount++;
      for (int k = 0; k < sizeBytes(memSize); k++)
        if ({32'b0, memAddr} + 64'(k) < 64'(MemBytes))
          dmem[int'(memAddr) + k] = memWdata[8*k +: 8];
    end
  endtask

  task automatic runCycle(input bit doRst);
    applyStimulus(doRst);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runUntilDrained(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || cyc < nextFree) && n < budget) begin
      runCycle(1'b0);
      n++;
    end
    checkVal("drain_pending", 32'(q0.size() + q1.size()), 32'h0);
  endtask

  initial begin
    int weBefore, reBefore;
    int fpCnt [2];
    checkCount = 0; passCount = 0; weCount = 0; reCount = 0;
    fpRspCount = 0; fpErrCount = 0;
    cyc = 0; nextFree = 0; lastGnt = 1;
    holdCnt[0] = 0; holdCnt[1] = 0;
    lastRdata[0] = '0; lastRdata[1] = '0; lastErr[0] = 1'b0; lastErr[1] = 1'b0;
    fpValid[0] = 1'b0; fpValid[1] = 1'b0;
    for (int i = 0; i < MaxCycles; i++) begin
      expMem[i].valid = 1'b0;
      expRsp[i].valid = 1'b0;
    end
    for (int i = 0; i < MemBytes; i++) begin
      dmem[i] = 8'($urandom);
      mdl[i]  = dmem[i];
    end
    rst = 1'b0;
    for (int p = 0; p < 2; p++) begin
      reqValid[p] = 1'b0; reqWe[p] = 1'b0; reqAddr[p] = '0; reqWdata[p] = '0; reqSize[p] = BYTE;
    end
    @(posedge clk);
    #1;
    runCycle(1'b1);
    runCycle(1'b1);

    $display("[TB] store/load word round trip");
    weBefore = weCount;
    pushReq(0, 1'b1, 32'h4, 32'hDEADBEEF, WORD, 0);
    pushReq(0, 1'b0, 32'h4, 32'h0, WORD, 0);
    runUntilDrained(40);
    checkVal("t1_load_rdata", lastRdata[0], 32'hDEADBEEF);
    checkVal("t1_load_err", 32'(lastErr[0]), 32'h0);
    checkVal("t1_we_pulses", 32'(weCount - weBefore), 32'h1);

    $display("[TB] round-robin between both ports");
    runCycle(1'b1);
    gntLog.delete();
    for (int i = 0; i < 4; i++) begin
      pushReq(0, 1'b0, 32'(4 * i), 32'h0, WORD, 0);
      pushReq(1, 1'b0, 32'(4 * i + 16), 32'h0, WORD, 0);
    end
    runUntilDrained(60);
    checkVal("t2_grant_count", 32'(gntLog.size()), 32'h8);
    for (int i = 0; i < 8 && i < gntLog.size(); i++)
      checkVal($sformatf("t2_grant%0d", i), 32'(gntLog[i]), 32'(i % 2));

    $display("[TB] misaligned port 1 loads");
    weBefore = weCount; reBefore = reCount;
    pushReq(1, 1'b0, 32'h3, 32'h0, HWORD, 0);
    runUntilDrained(20);
    checkVal("t3_hword_err", 32'(lastErr[1]), 32'h1);
    pushReq(1, 1'b0, 32'h6, 32'h0, WORD, 0);
    runUntilDrained(20);
    checkVal("t3_word_err", 32'(lastErr[1]), 32'h1);
    checkVal("t3_word_rdata", lastRdata[1], 32'h0);
    checkVal("t3_strobes", 32'((weCount - weBefore) + (reCount - reBefore)), 32'h0);

    $display("[TB] range boundary stores");
    weBefore = weCount;
    pushReq(0, 1'b1, 32'h1C, 32'hCAFEF00D, WORD, 0);
    runUntilDrained(20);
    checkVal("t4_top_word_err", 32'(lastErr[0]), 32'h0);
    pushReq(0, 1'b1, 32'h1E, 32'h11111111, WORD, 0);
    runUntilDrained(20);
    checkVal("t4_1e_err", 32'(lastErr[0]), 32'h1);
    pushReq(0, 1'b1, 32'h20, 32'h22222222, WORD, 0);
    runUntilDrained(20);
    checkVal("t4_20_err", 32'(lastErr[0]), 32'h1);
    pushReq(0, 1'b1, 32'hFFFFFFFF, 32'h33, BYTE, 0);
    runUntilDrained(20);
    checkVal("t4_wrap_err", 32'(lastErr[0]), 32'h1);
    checkVal("t4_we_pulses", 32'(weCount - weBefore), 32'h1);

    $display("[TB] byte store then halfword load");
    pushReq(0, 1'b1, 32'h8, 32'h0, BYTE, 0);
    pushReq(0, 1'b1, 32'h9, 32'hA5, BYTE, 0);
    pushReq(0, 1'b0, 32'h8, 32'h0, HWORD, 0);
    runUntilDrained(40);
    checkVal("t5_hword_rdata", lastRdata[0], 32'h0000A500);

    $display("[TB] reset during the access cycle of a store");
    weBefore = weCount;
    pushReq(0, 1'b1, 32'h10, 32'h12345678, WORD, 0);
    runCycle(1'b0);
    runCycle(1'b1);
    runCycle(1'b1);
    checkVal("t6_no_write", 32'(weCount - weBefore), 32'h0);
    gntLog.delete();
    pushReq(0, 1'b0, 32'h10, 32'h0, WORD, 0);
    pushReq(1, 1'b0, 32'h14, 32'h0, WORD, 0);
    runUntilDrained(40);
    checkVal("t6_first_grant", 32'((gntLog.size() > 0) ? gntLog[0] : 9), 32'h0);

    $display("[TB] fixed-priority instance");
    fpLog.delete();
    fpRspCount = 0;
    fpErrCount = 0;
    fpCnt[0] = 0;
    fpCnt[1] = 0;
    for (int n = 0; n < 60 && (fpCnt[0] < 4 || fpCnt[1] < 4); n++) begin
      fpValid[0] = (fpCnt[0] < 4);
      fpValid[1] = (fpCnt[1] < 4);
      runCycle(1'b0);
      fpCnt[0] = 0;
      fpCnt[1] = 0;
      foreach (fpLog[i]) fpCnt[fpLog[i]]++;
    end
    fpValid[0] = 1'b0;
    fpValid[1] = 1'b0;
    for (int n = 0; n < 3; n++) runCycle(1'b0);
    checkVal("fp_grant_count", 32'(fpLog.size()), 32'h8);
    for (int i = 0; i < 8 && i < fpLog.size(); i++)
      checkVal($sformatf("fp_grant%0d", i), 32'(fpLog[i]), 32'(i / 4));
    checkVal("fp_rsp_count", 32'(fpRspCount), 32'h8);
    checkVal("fp_err_count", 32'(fpErrCount), 32'h0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      req_t r;
      r.we    = 1'($urandom_range(0, 1));
      r.addr  = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 35)) : $urandom;
      r.wdata = $urandom;
      r.size  = ($urandom_range(0, 9) == 0) ? mem_op_sz_e'(2'b11)
                                            : mem_op_sz_e'(2'($urandom_range(0, 2)));
      r.gap   = int'($urandom_range(0, 3));
      pushReq(int'($urandom_range(0, 1)), r.we, r.addr, r.wdata, r.size, r.gap);
    end
    for (int n = 0; n < 5000 && (q0.size() > 0 || q1.size() > 0); n++)
      runCycle($urandom_range(0, 199) == 0);
    runUntilDrained(20);

    for (int i = 0; i < MemBytes; i++)
      checkVal($sformatf("mem_byte%0d", i), 32'(dmem[i]), 32'(mdl[i]));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
